// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
// One result bit per cycle; shift-add multiply, restoring divide, sign correction in FIN.
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic [31:0] a_q, a_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        signed_op;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] mul_res;
  logic [31:0] quo_res, rem_res;

  assign signed_op = (Op == OP_MULT) || (Op == OP_DIV);
  assign a_neg     = signed_op && A[31];
  assign b_neg     = signed_op && B[31];
  assign abs_a     = a_neg ? (32'd0 - A) : A;
  assign abs_b     = b_neg ? (32'd0 - B) : B;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each cycle.
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_b_q} : 33'd0);

  // Divide: acc = {partial remainder, dividend/quotient}, shifted left each cycle.
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = div_shift >= {1'b0, mag_b_q};
  assign div_sub   = div_shift[31:0] - mag_b_q;

  assign mul_res   = neg_res_q ? (64'd0 - acc_q) : acc_q;
  assign quo_res   = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_res   = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_b_d   = mag_b_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start && !flush) begin
          if (!Op[2]) begin
            state_d   = RUN;
            cnt_d     = 6'd0;
            acc_d     = {32'd0, abs_a};
            mag_b_d   = abs_b;
            a_d       = A;
            is_div_d  = Op[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end else if (Op == OP_MTHI) begin
            hi_d = A;
          end else if (Op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = div_ge ? {div_sub, acc_q[30:0], 1'b1}
                           : {div_shift[31:0], acc_q[30:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[31:1]};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = mul_res[63:32];
            lo_d = mul_res[31:0];
          end else if (mag_b_q == 32'd0) begin
            hi_d  = a_q;
            lo_d  = 32'hFFFF_FFFF;
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_res;
            lo_d = quo_res;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      mag_b_q   <= 32'd0;
      a_q       <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mag_b_q   <= mag_b_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule
